// File: rtl/seq_pkg.sv
// Round sequencer states and the on-screen countdown width.
`timescale 1ns/1ps
package seq_pkg;
    localparam int CD_W = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        COUNTDOWN  = 3'd2,
        PLAYING    = 3'd3,
        HOLD       = 3'd4
    } s_state;
endpackage

// File: rtl/state_pkg.sv
// Game state machine encoding shared with the round sequencer.
`timescale 1ns/1ps
package state_pkg;
    typedef enum logic [1:0] {
        START  = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } g_state;
endpackage

// File: rtl/sec_tick.sv
// One-second tick generator; clr marks the first cycle of a new interval,
// so the first tick fires TICK_CYCLES cycles after the clear began.
`timescale 1ns/1ps
module sec_tick #(
    parameter int TICK_CYCLES = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST      = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] AFTER_CLR = (TICK_CYCLES > 1) ? CW'(1) : '0;

    logic [CW-1:0] cnt;

    // The clear cycle itself counts as cycle 0 of the interval.
    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= AFTER_CLR;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/game_sequencer.sv
// Two-player ready handshake, countdown and restart gating for the game FSM.
// Optional macro GAME_SEQ_TIMEOUT_EN enables the WAIT_READY timeout.
`timescale 1ns/1ps
module game_sequencer
    import state_pkg::*;
    import seq_pkg::*;
#(
    parameter int TICK_CYCLES       = 65_000_000,
    parameter int COUNT_SEC         = 3,
    parameter int READY_TIMEOUT_SEC = 5,
    parameter int FINISH_HOLD_SEC   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  g_state          game_state,
    input  logic            ready_local,
    input  logic            ready_remote,
    input  logic            restart_req,
    output logic            start_go,
    output logic            restart_go,
    output logic [CD_W-1:0] countdown,
    output s_state          seq_state,
    output logic            local_seen,
    output logic            remote_seen,
    output logic            timeout
);
    localparam int SEC_MAX = (READY_TIMEOUT_SEC > FINISH_HOLD_SEC) ? READY_TIMEOUT_SEC
                                                                   : FINISH_HOLD_SEC;
    localparam int SW = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;
    localparam logic [SW-1:0]   HOLD_DONE = SW'(FINISH_HOLD_SEC);
    localparam logic [CD_W-1:0] CD_INIT   = CD_W'(COUNT_SEC);
    localparam logic [CD_W-1:0] CD_LAST   = CD_W'(1);

    logic [2:0]    req_raw, sync1, sync2, req_prev, req_edge;
    logic          local_edge, remote_edge, restart_edge;
    s_state        prev_state;
    logic          tick_clr, tick;
    logic [SW-1:0] sec_cnt;

`ifdef GAME_SEQ_TIMEOUT_EN
    localparam logic [SW-1:0] TIMEOUT_LAST = SW'(READY_TIMEOUT_SEC - 1);
    logic timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign req_raw      = {restart_req, ready_remote, ready_local};
    assign local_edge   = req_edge[0];
    assign remote_edge  = req_edge[1];
    assign restart_edge = req_edge[2];

    // Two synchronizer flops, then a registered rising-edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            req_prev <= '0;
            req_edge <= '0;
        end else begin
            sync1    <= req_raw;
            sync2    <= sync1;
            req_prev <= sync2;
            req_edge <= sync2 & ~req_prev;
        end
    end

    assign tick_clr = (seq_state != prev_state);

    sec_tick #(.TICK_CYCLES(TICK_CYCLES)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_state   <= IDLE;
            prev_state  <= IDLE;
            countdown   <= '0;
            sec_cnt     <= '0;
            local_seen  <= 1'b0;
            remote_seen <= 1'b0;
            start_go    <= 1'b0;
            restart_go  <= 1'b0;
`ifdef GAME_SEQ_TIMEOUT_EN
            timeout_r   <= 1'b0;
`endif
        end else begin
            start_go   <= 1'b0;
            restart_go <= 1'b0;
`ifdef GAME_SEQ_TIMEOUT_EN
            timeout_r  <= 1'b0;
`endif
            prev_state <= seq_state;
            case (seq_state)
                IDLE: begin
                    if (local_edge && remote_edge) begin
                        seq_state   <= COUNTDOWN;
                        countdown   <= CD_INIT;
                        local_seen  <= 1'b0;
                        remote_seen <= 1'b0;
                    end else if (local_edge || remote_edge) begin
                        seq_state   <= WAIT_READY;
                        local_seen  <= local_edge;
                        remote_seen <= remote_edge;
                        sec_cnt     <= '0;
                    end
                end
                WAIT_READY: begin
                    if ((local_edge && !local_seen) || (remote_edge && !remote_seen)) begin
                        seq_state   <= COUNTDOWN;
                        countdown   <= CD_INIT;
                        local_seen  <= 1'b0;
                        remote_seen <= 1'b0;
                        sec_cnt     <= '0;
                    end
`ifdef GAME_SEQ_TIMEOUT_EN
                    else if (tick) begin
                        if (sec_cnt == TIMEOUT_LAST) begin
                            timeout_r   <= 1'b1;
                            seq_state   <= IDLE;
                            local_seen  <= 1'b0;
                            remote_seen <= 1'b0;
                            sec_cnt     <= '0;
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end
`endif
                end
                COUNTDOWN: begin
                    if (tick) begin
                        if (countdown == CD_LAST) begin
                            countdown <= '0;
                            start_go  <= 1'b1;
                            seq_state <= PLAYING;
                        end else begin
                            countdown <= countdown - 1'b1;
                        end
                    end
                end
                PLAYING: begin
                    // The game FSM is still in START while start_go is high.
                    if (game_state == START && !start_go) begin
                        seq_state <= IDLE;
                        countdown <= '0;
                        sec_cnt   <= '0;
                    end else if (game_state == FINISH) begin
                        seq_state <= HOLD;
                        sec_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (game_state == START) begin
                        seq_state <= IDLE;
                        countdown <= '0;
                        sec_cnt   <= '0;
                    end else if (sec_cnt != HOLD_DONE) begin
                        if (tick) begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end else if (restart_edge) begin
                        restart_go <= 1'b1;
                        seq_state  <= IDLE;
                        sec_cnt    <= '0;
                    end
                end
                default: begin
                    seq_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer; expected output snapshots are queued with
// the stimulus and compared at their cycle. Covers GAME_SEQ_TIMEOUT_EN on or off.
`timescale 1ns/1ps
module tb_game_sequencer;
    import state_pkg::*;
    import seq_pkg::*;

    typedef struct packed {
        s_state     st;
        logic [2:0] cd;
        logic       ls;
        logic       rs;
        logic       sg;
        logic       rg;
        logic       to;
    } obs_t;

    typedef struct {
        int    t;
        string name;
        obs_t  v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    g_state     game_state = PLAY;
    logic       ready_local = 1'b0;
    logic       ready_remote = 1'b0;
    logic       restart_req = 1'b0;
    logic       start_go, restart_go, local_seen, remote_seen, timeout;
    logic [2:0] countdown;
    s_state     seq_state;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    game_sequencer #(
        .TICK_CYCLES       (10),
        .COUNT_SEC         (3),
        .READY_TIMEOUT_SEC (5),
        .FINISH_HOLD_SEC   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .ready_local  (ready_local),
        .ready_remote (ready_remote),
        .restart_req  (restart_req),
        .start_go     (start_go),
        .restart_go   (restart_go),
        .countdown    (countdown),
        .seq_state    (seq_state),
        .local_seen   (local_seen),
        .remote_seen  (remote_seen),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic obs_t snap();
        obs_t o;
        o.st = seq_state;
        o.cd = countdown;
        o.ls = local_seen;
        o.rs = remote_seen;
        o.sg = start_go;
        o.rg = restart_go;
        o.to = timeout;
        return o;
    endfunction

    function automatic void push_exp(input int t, input string name, input s_state st,
                                     input int cd, input logic ls, input logic rs,
                                     input logic sg, input logic rg, input logic to);
        exp_t e;
        e.t    = t;
        e.name = name;
        e.v.st = st;
        e.v.cd = 3'(cd);
        e.v.ls = ls;
        e.v.rs = rs;
        e.v.sg = sg;
        e.v.rg = rg;
        e.v.to = to;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        obs_t zero;
        zero = '0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (snap() !== zero) begin
            errors++;
            $display("[TB] FAIL reset_async got=%b exp=%b", snap(), zero);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (snap() !== zero) begin
            errors++;
            $display("[TB] FAIL reset_idle got=%b exp=%b", snap(), zero);
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        push_exp(4,  "hs_idle",      IDLE,       0, 1, 0, 0, 0, 0);
        sb[0].v.ls = 1'b0;
        push_exp(5,  "hs_wait",      WAIT_READY, 0, 1, 0, 0, 0, 0);
        push_exp(24, "hs_wait_last", WAIT_READY, 0, 1, 0, 0, 0, 0);
        push_exp(25, "hs_cd3",       COUNTDOWN,  3, 0, 0, 0, 0, 0);
        push_exp(34, "hs_cd3_end",   COUNTDOWN,  3, 0, 0, 0, 0, 0);
        push_exp(35, "hs_cd2",       COUNTDOWN,  2, 0, 0, 0, 0, 0);
        push_exp(44, "hs_cd2_end",   COUNTDOWN,  2, 0, 0, 0, 0, 0);
        push_exp(45, "hs_cd1",       COUNTDOWN,  1, 0, 0, 0, 0, 0);
        push_exp(54, "hs_cd1_end",   COUNTDOWN,  1, 0, 0, 0, 0, 0);
        push_exp(55, "hs_start_go",  PLAYING,    0, 0, 0, 1, 0, 0);
        push_exp(56, "hs_playing",   PLAYING,    0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 60; t++) begin
            @(posedge clk); #1;
            if (t == 1)  ready_local  = 1'b1;
            if (t == 21) ready_remote = 1'b1;
            if (t == 57) begin ready_local = 1'b0; ready_remote = 1'b0; end
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL handshake_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_restart();
        exp_t e;
        push_exp(1,  "rs_playing",   PLAYING, 0, 0, 0, 0, 0, 0);
        push_exp(2,  "rs_hold",      HOLD,    0, 0, 0, 0, 0, 0);
        push_exp(8,  "rs_early_ign", HOLD,    0, 0, 0, 0, 0, 0);
        push_exp(26, "rs_hold_end",  HOLD,    0, 0, 0, 0, 0, 0);
        push_exp(27, "rs_restart",   IDLE,    0, 0, 0, 0, 1, 0);
        push_exp(28, "rs_idle",      IDLE,    0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 32; t++) begin
            @(posedge clk); #1;
            if (t == 1)  game_state  = FINISH;
            if (t == 3)  restart_req = 1'b1;
            if (t == 10) restart_req = 1'b0;
            if (t == 23) restart_req = 1'b1;
            if (t == 27) game_state  = PLAY;
            if (t == 28) restart_req = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        push_exp(2,  "sim_idle2",    IDLE,      0, 0, 0, 0, 0, 0);
        push_exp(3,  "sim_idle3",    IDLE,      0, 0, 0, 0, 0, 0);
        push_exp(4,  "sim_idle4",    IDLE,      0, 0, 0, 0, 0, 0);
        push_exp(5,  "sim_cd3",      COUNTDOWN, 3, 0, 0, 0, 0, 0);
        push_exp(35, "sim_start_go", PLAYING,   0, 0, 0, 1, 0, 0);
        push_exp(36, "sim_playing",  PLAYING,   0, 0, 0, 0, 0, 0);
        push_exp(41, "sim_ext_rst",  IDLE,      0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 45; t++) begin
            @(posedge clk); #1;
            if (t == 1)  begin ready_local = 1'b1; ready_remote = 1'b1; end
            if (t == 36) begin ready_local = 1'b0; ready_remote = 1'b0; end
            if (t == 40) game_state = START;
            if (t == 42) game_state = PLAY;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL simultaneous_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

`ifdef GAME_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        push_exp(5,  "to_wait",     WAIT_READY, 0, 1, 0, 0, 0, 0);
        push_exp(54, "to_wait_end", WAIT_READY, 0, 1, 0, 0, 0, 0);
        push_exp(55, "to_pulse",    IDLE,       0, 0, 0, 0, 0, 1);
        push_exp(56, "to_idle",     IDLE,       0, 0, 0, 0, 0, 0);
        push_exp(70, "to_held",     IDLE,       0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 75; t++) begin
            @(posedge clk); #1;
            if (t == 1)  ready_local = 1'b1;
            if (t == 71) ready_local = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask
`else
    task automatic test_no_timeout();
        exp_t e;
        for (int k = 0; k <= 10; k++) begin
            push_exp(5 + 50 * k, "nto_wait", WAIT_READY, 0, 0, 1, 0, 0, 0);
        end
        for (int t = 1; t <= 506; t++) begin
            @(posedge clk); #1;
            if (t == 1)   ready_remote = 1'b1;
            if (t == 506) ready_remote = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL no_timeout_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask
`endif

    task automatic test_async_reset();
        exp_t e;
        obs_t zero;
        zero = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_local = 1'b0;
        ready_remote = 1'b0;
        restart_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_exp(5,  "ar_cd3",   COUNTDOWN, 3, 0, 0, 0, 0, 0);
        push_exp(14, "ar_cd3b",  COUNTDOWN, 3, 0, 0, 0, 0, 0);
        push_exp(15, "ar_cd2",   COUNTDOWN, 2, 0, 0, 0, 0, 0);
        push_exp(18, "ar_after", IDLE,      0, 0, 0, 0, 0, 0);
        push_exp(25, "ar_quiet", IDLE,      0, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 26; t++) begin
            @(posedge clk); #1;
            if (t == 1)  begin ready_local = 1'b1; ready_remote = 1'b1; end
            if (t == 10) begin ready_local = 1'b0; ready_remote = 1'b0; end
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t == t) begin
                e = sb.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    errors++;
                    $display("[TB] FAIL %s t=%0d got=%b exp=%b", e.name, t, snap(), e.v);
                end
            end
            if (t == 17) begin
                #2 rst = 1'b0;
                #0.5;
                checks++;
                if (snap() !== zero) begin
                    errors++;
                    $display("[TB] FAIL ar_mid_countdown got=%b exp=%b", snap(), zero);
                end
                #0.5 rst = 1'b1;
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL async_reset_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_restart();
        test_simultaneous();
`ifdef GAME_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
